// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter for instruction fetch (IF) and load/store (MEM).
// Serialises 1/2/4-byte accesses into per-byte RAM cycles and assembles
// little-endian words. MEM has priority; IO stores wait while the IO buffer is full.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_stall_req_o,
  input  logic                  mem_req_i,
  input  logic                  mem_wr_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [1:0]            mem_size_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_stall_req_o,
  input  logic                  io_buffer_full_i,
  input  logic [7:0]            mem_din_i,
  output logic [7:0]            mem_dout_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_wr_o
);

  typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_e;

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic [31:0]           buf_q;
  logic                  if_done_q;
  logic                  mem_done_q;
  logic [31:0]           if_inst_q;
  logic [31:0]           mem_rdata_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [7:0]            dout_q;
  logic                  wr_q;

  logic       io_block;
  logic       can_sample;
  logic       mem_go;
  logic       if_go;
  logic [2:0] mem_len;
  logic [7:0] wr_byte;
  logic [1:0] rd_idx;
  logic [31:0] buf_nxt;
  logic [2:0] last_cnt;

  // Request arbitration and datapath helpers for the current byte beat.
  always_comb begin
    io_block   = mem_wr_i && (mem_addr_i >= IO_BASE) && io_buffer_full_i;
    // Dead cycle after a done pulse lets the requester drop its request.
    can_sample = !if_done_q && !mem_done_q;
    mem_go     = can_sample && mem_req_i && !io_block;
    if_go      = can_sample && if_req_i && !if_flush_i && !mem_go;
    unique case (mem_size_i)
      2'd0:    mem_len = 3'd1;
      2'd1:    mem_len = 3'd2;
      default: mem_len = 3'd4;
    endcase
    wr_byte  = mem_wdata_i[{cnt_q[1:0], 3'b000} +: 8];
    // RAM data lags the address by one cycle, so beat k returns byte k-2.
    rd_idx   = 2'(cnt_q - 3'd2);
    buf_nxt  = buf_q;
    buf_nxt[{rd_idx, 3'b000} +: 8] = mem_din_i;
    last_cnt = len_q + 3'd1;
  end

  // Access FSM with all RAM-side and result outputs registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      buf_q       <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      a_q         <= '0;
      dout_q      <= 8'd0;
      wr_q        <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_go) begin
            a_q   <= mem_addr_i[ADDR_WIDTH-1:0];
            cnt_q <= 3'd1;
            len_q <= mem_len;
            buf_q <= 32'd0;
            if (mem_wr_i) begin
              wr_q    <= 1'b1;
              dout_q  <= mem_wdata_i[7:0];
              state_q <= StMemWr;
            end else begin
              state_q <= StMemRd;
            end
          end else if (if_go) begin
            a_q     <= if_addr_i[ADDR_WIDTH-1:0];
            cnt_q   <= 3'd1;
            len_q   <= 3'd4;
            buf_q   <= 32'd0;
            state_q <= StIfRd;
          end
        end
        StIfRd, StMemRd: begin
          if (state_q == StIfRd && if_flush_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
          end else begin
            if (cnt_q < len_q) a_q <= a_q + ADDR_WIDTH'(1);
            if (cnt_q >= 3'd2) buf_q <= buf_nxt;
            if (cnt_q == last_cnt) begin
              if (state_q == StIfRd) begin
                if_done_q <= 1'b1;
                if_inst_q <= buf_nxt;
              end else begin
                mem_done_q  <= 1'b1;
                mem_rdata_q <= buf_nxt;
              end
              state_q <= StIdle;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StMemWr: begin
          if (cnt_q == len_q) begin
            wr_q       <= 1'b0;
            mem_done_q <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
          end else begin
            wr_q   <= 1'b1;
            a_q    <= a_q + ADDR_WIDTH'(1);
            dout_q <= wr_byte;
            cnt_q  <= cnt_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_done_o       = if_done_q;
  assign if_inst_o       = if_inst_q;
  assign mem_done_o      = mem_done_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign mem_a_o         = a_q;
  assign mem_dout_o      = dout_q;
  assign mem_wr_o        = wr_q;
  assign if_stall_req_o  = if_req_i & ~if_done_q;
  assign mem_stall_req_o = mem_req_i & ~mem_done_q;

endmodule
